// File: rtl/interface_controller_out.sv
// rtl/interface_controller_out.sv - decodes framed commands popped from the ingress command FIFO
// Optional completed-message counter on msg_count_o: define INTERFACE_OUT_MSG_COUNT_EN.
module interface_controller_out #(
    parameter int HOST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty_i,
    input  logic [7:0]        data_i,
    output logic              readreq_o,
    output logic              connect_valid_o,
    output logic              disconnect_valid_o,
    output logic [HOST_W-1:0] host_addr_o,
    output logic              msg_start_o,
    output logic [7:0]        msg_length_o,
    output logic              payload_valid_o,
    output logic [7:0]        payload_data_o,
    output logic              payload_last_o,
    input  logic              payload_ready_i,
    output logic              error_o,
    output logic [15:0]       msg_count_o
);
    typedef enum logic [2:0] {
        CMD_REQ, CMD_WAIT, LEN_REQ, LEN_WAIT, PAY_REQ, PAY_WAIT, PAY_HOLD
    } state_t;

    state_t     state;
    logic       outstanding;
    logic [7:0] remaining;
    logic       in_req;
    logic       pop;
    logic [2:0] opcode;
    logic       cmd_legal;

    assign in_req    = (state == CMD_REQ) || (state == LEN_REQ) || (state == PAY_REQ);
    // Gated by rst so a pop can never be lost while the frame is being abandoned.
    assign pop       = in_req && !empty_i && !outstanding && !rst;
    assign readreq_o = pop;
    assign opcode    = data_i[2:0];
    assign cmd_legal = ((data_i >> (3 + HOST_W)) == 8'd0) && (opcode <= 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= CMD_REQ;
            outstanding        <= 1'b0;
            remaining          <= 8'd0;
            connect_valid_o    <= 1'b0;
            disconnect_valid_o <= 1'b0;
            host_addr_o        <= '0;
            msg_start_o        <= 1'b0;
            msg_length_o       <= 8'd0;
            payload_valid_o    <= 1'b0;
            payload_data_o     <= 8'd0;
            payload_last_o     <= 1'b0;
            error_o            <= 1'b0;
        end else begin
            connect_valid_o    <= 1'b0;
            disconnect_valid_o <= 1'b0;
            msg_start_o        <= 1'b0;
            error_o            <= 1'b0;
            case (state)
                CMD_REQ: begin
                    if (pop) begin
                        outstanding <= 1'b1;
                        state       <= CMD_WAIT;
                    end
                end
                CMD_WAIT: begin
                    outstanding <= 1'b0;
                    if (!cmd_legal) begin
                        error_o <= 1'b1;
                        state   <= CMD_REQ;
                    end else begin
                        host_addr_o <= data_i[2+HOST_W:3];
                        case (opcode)
                            3'd0: begin
                                connect_valid_o <= 1'b1;
                                state           <= CMD_REQ;
                            end
                            3'd1: begin
                                disconnect_valid_o <= 1'b1;
                                state              <= CMD_REQ;
                            end
                            default: state <= LEN_REQ;
                        endcase
                    end
                end
                LEN_REQ: begin
                    if (pop) begin
                        outstanding <= 1'b1;
                        state       <= LEN_WAIT;
                    end
                end
                LEN_WAIT: begin
                    outstanding  <= 1'b0;
                    msg_length_o <= data_i;
                    msg_start_o  <= 1'b1;
                    remaining    <= data_i;
                    state        <= (data_i == 8'd0) ? CMD_REQ : PAY_REQ;
                end
                PAY_REQ: begin
                    if (pop) begin
                        outstanding <= 1'b1;
                        state       <= PAY_WAIT;
                    end
                end
                PAY_WAIT: begin
                    outstanding     <= 1'b0;
                    payload_data_o  <= data_i;
                    payload_valid_o <= 1'b1;
                    payload_last_o  <= (remaining == 8'd1);
                    state           <= PAY_HOLD;
                end
                PAY_HOLD: begin
                    if (payload_ready_i) begin
                        payload_valid_o <= 1'b0;
                        payload_last_o  <= 1'b0;
                        remaining       <= remaining - 8'd1;
                        state           <= payload_last_o ? CMD_REQ : PAY_REQ;
                    end
                end
                default: state <= CMD_REQ;
            endcase
        end
    end

`ifdef INTERFACE_OUT_MSG_COUNT_EN
    logic [15:0] msg_count;

    // A message completes on its zero length byte or when its last payload byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_count <= 16'h0;
        end else if (((state == LEN_WAIT) && (data_i == 8'd0)) ||
                     ((state == PAY_HOLD) && payload_ready_i && payload_last_o)) begin
            msg_count <= msg_count + 16'd1;
        end
    end

    assign msg_count_o = msg_count;
`else
    assign msg_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_interface_controller_out.sv
// tb/tb_interface_controller_out.sv - randomized bench for interface_controller_out
// Expected events come from a frame-level model; a queue stands in for the ingress FIFO.
module tb_interface_controller_out;
    localparam int HOST_W = 4;
    localparam logic [7:0] EV_CON = 8'd1, EV_DIS = 8'd2, EV_ERR = 8'd3, EV_MSG = 8'd4, EV_PAY = 8'd5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              empty_i = 1'b1;
    logic [7:0]        data_i = 8'h0;
    logic              readreq_o;
    logic              connect_valid_o;
    logic              disconnect_valid_o;
    logic [HOST_W-1:0] host_addr_o;
    logic              msg_start_o;
    logic [7:0]        msg_length_o;
    logic              payload_valid_o;
    logic [7:0]        payload_data_o;
    logic              payload_last_o;
    logic              payload_ready_i = 1'b0;
    logic              error_o;
    logic [15:0]       msg_count_o;

    interface_controller_out #(.HOST_W(HOST_W)) dut (
        .clk(clk), .rst(rst), .empty_i(empty_i), .data_i(data_i), .readreq_o(readreq_o),
        .connect_valid_o(connect_valid_o), .disconnect_valid_o(disconnect_valid_o),
        .host_addr_o(host_addr_o), .msg_start_o(msg_start_o), .msg_length_o(msg_length_o),
        .payload_valid_o(payload_valid_o), .payload_data_o(payload_data_o),
        .payload_last_o(payload_last_o), .payload_ready_i(payload_ready_i),
        .error_o(error_o), .msg_count_o(msg_count_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  pay_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [15:0] exp_count = 16'h0;
    int          pops = 0;
    int          cyc = 0;
    int          ready_mode = 2;
    int          stall_left = 0;
    logic [7:0]  stall_byte = 8'h0;
    bit          tput_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [7:0] t, input logic [7:0] a, input logic [7:0] b);
        return {t, a, b, 8'h0};
    endfunction

    function automatic logic [63:0] outs();
        return {17'h0, readreq_o, connect_valid_o, disconnect_valid_o, 8'(host_addr_o), msg_start_o,
                msg_length_o, payload_valid_o, payload_data_o, payload_last_o, error_o, msg_count_o};
    endfunction

    // FIFO: data appears the cycle after a pop.
    initial begin
        forever begin
            @(posedge clk);
            if (readreq_o) begin
                pops++;
                if (fifo_q.size() > 0) data_i <= fifo_q.pop_front();
            end
            empty_i <= (fifo_q.size() == 0);
        end
    end

    // Consumer and monitor: drives ready at the falling edge, then records what the DUT shows.
    initial begin
        bit         acc, prev_pv, prev_acc, have_prev;
        logic [7:0] prev_pd;
        logic       prev_pl;
        int         prev_cyc, nstrobe;
        prev_pv = 0; prev_acc = 0; have_prev = 0; prev_pd = 0; prev_pl = 0; prev_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       payload_ready_i = 1'($urandom_range(0, 1));
                1:       payload_ready_i = 1'b1;
                default: payload_ready_i = 1'b0;
            endcase
            if (stall_left > 0 && payload_valid_o && payload_data_o == stall_byte) begin
                payload_ready_i = 1'b0;
                stall_left--;
                check("stall_no_pop", 64'(readreq_o), 64'd0);
                check("stall_data", 64'(payload_data_o), 64'(stall_byte));
            end
            if (rst) begin
                prev_pv = 0;
                have_prev = 0;
            end else begin
                acc = payload_valid_o && payload_ready_i;
                nstrobe = int'(connect_valid_o) + int'(disconnect_valid_o) + int'(msg_start_o) + int'(error_o);
                check("one_strobe", 64'(nstrobe <= 1), 64'd1);
                check("no_underflow", 64'(readreq_o && empty_i), 64'd0);
                if (prev_pv && !prev_acc)
                    check("hold_stable", 64'({payload_valid_o, payload_data_o, payload_last_o}),
                          64'({1'b1, prev_pd, prev_pl}));
                if (connect_valid_o)    obs_q.push_back(ev(EV_CON, 8'(host_addr_o), 8'h0));
                if (disconnect_valid_o) obs_q.push_back(ev(EV_DIS, 8'(host_addr_o), 8'h0));
                if (error_o)            obs_q.push_back(ev(EV_ERR, 8'h0, 8'h0));
                if (msg_start_o)        obs_q.push_back(ev(EV_MSG, 8'(host_addr_o), msg_length_o));
                if (acc) begin
                    obs_q.push_back(ev(EV_PAY, payload_data_o, 8'(payload_last_o)));
                    if (tput_on && have_prev) check("tput_gap", 64'(cyc - prev_cyc), 64'd3);
                    prev_cyc = cyc;
                    have_prev = !payload_last_o;
                end
                prev_pv = payload_valid_o; prev_pd = payload_data_o;
                prev_pl = payload_last_o;  prev_acc = acc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        empty_i = 1'b0;
    endtask

    // Frame-level model: what a command byte must produce.
    task automatic expect_cmd(input logic [7:0] cmd, output bit is_send, output logic [7:0] host);
        int op, upper;
        op    = int'(cmd) % 8;
        host  = 8'((int'(cmd) / 8) % (1 << HOST_W));
        upper = int'(cmd) / (8 << HOST_W);
        is_send = 1'b0;
        if (upper != 0 || op > 2) exp_q.push_back(ev(EV_ERR, 8'h0, 8'h0));
        else if (op == 0)         exp_q.push_back(ev(EV_CON, host, 8'h0));
        else if (op == 1)         exp_q.push_back(ev(EV_DIS, host, 8'h0));
        else                      is_send = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int len);
        bit         is_send;
        logic [7:0] host, b;
        push_byte(cmd);
        expect_cmd(cmd, is_send, host);
        if (is_send) begin
            push_byte(8'(len));
            exp_q.push_back(ev(EV_MSG, host, 8'(len)));
            for (int i = 0; i < len; i++) begin
                b = (i < pay_q.size()) ? pay_q[i] : 8'($urandom);
                push_byte(b);
                exp_q.push_back(ev(EV_PAY, b, 8'(i == len - 1)));
            end
            exp_count++;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_nev"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_ev"}, 64'((i < obs_q.size()) ? obs_q[i] : 32'hFFFF_FFFF), 64'(exp_q[i]));
`ifdef INTERFACE_OUT_MSG_COUNT_EN
        check({tag, "_msg_count"}, 64'(msg_count_o), 64'(exp_count));
`else
        check({tag, "_msg_count"}, 64'(msg_count_o), 64'd0);
`endif
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 4000;
        while ((fifo_q.size() != 0 || obs_q.size() < exp_q.size()) && budget > 0) begin
            step();
            budget--;
        end
        repeat (4) step();
        check({tag, "_timeout"}, 64'(budget == 0), 64'd0);
        compare(tag);
    endtask

    initial begin
        int         p0, budget, kind, len;
        bit         is_send;
        logic [7:0] host, cmd;

        repeat (3) step();
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        ready_mode = 1;

        p0 = pops;
        send_frame(8'h28, 0);
        drain("connect");
        check("connect_pops", 64'(pops - p0), 64'd1);
        check("connect_host", 64'(host_addr_o), 64'd5);

        send_frame(8'h19, 0);
        drain("disconnect");
        check("disconnect_host", 64'(host_addr_o), 64'd3);

        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        tput_on = 1'b1;
        send_frame(8'h12, 3);
        drain("send3");
        tput_on = 1'b0;

        stall_byte = 8'hBB;
        stall_left = 10;
        send_frame(8'h12, 3);
        drain("stall");
        check("stall_done", 64'(stall_left), 64'd0);

        send_frame(8'h03, 0);
        send_frame(8'h28, 0);
        drain("error_then_connect");
        send_frame(8'h12, 0);
        drain("len0");

        pay_q.delete();
        tput_on = 1'b1;
        send_frame(8'h12, 255);
        drain("len255");
        tput_on = 1'b0;

        // Reset while a length-3 frame sits in PAY_HOLD.
        ready_mode = 2;
        push_byte(8'h12); push_byte(8'h03); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        exp_q.push_back(ev(EV_MSG, 8'h2, 8'h3));
        budget = 50;
        while (!payload_valid_o && budget > 0) begin
            step();
            budget--;
        end
        check("reach_hold", 64'(payload_valid_o), 64'd1);
        check("hold_data", 64'(payload_data_o), 64'hAA);
        compare("pre_reset");
        rst = 1'b1;
        step();
        check("reset_mid_frame", outs(), 64'd0);
        rst = 1'b0;
        exp_count = 16'h0;
        expect_cmd(8'hBB, is_send, host);
        expect_cmd(8'hCC, is_send, host);
        ready_mode = 0;
        send_frame(8'h28, 0);
        drain("after_reset");

        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 4);
            host = 8'($urandom_range(0, (1 << HOST_W) - 1));
            len  = $urandom_range(0, 6);
            case (kind)
                0:       cmd = 8'(int'(host) * 8);
                1:       cmd = 8'(int'(host) * 8 + 1);
                4:       cmd = ($urandom_range(0, 1) == 1) ? 8'(int'(host) * 8 + $urandom_range(3, 7))
                                                          : 8'(128 + int'(host) * 8 + $urandom_range(0, 2));
                default: cmd = 8'(int'(host) * 8 + 2);
            endcase
            send_frame(cmd, len);
            repeat ($urandom_range(0, 6)) step();
            if (f % 20 == 19) drain("random");
        end
        drain("random_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/interface_controller_out.md
Name: interface_controller_out

Overview:
- Downstream consumer of the ingress command FIFO that the ingress interface controller fills.
- Pops bytes from the FIFO and decodes framed commands: connect, disconnect, and send_data.
- A send_data frame is a command byte, then a length byte, then that many payload bytes.
- Emits single-cycle connect/disconnect strobes to the session logic, and streams payload bytes to the message builder over a valid/ready handshake.

Parameters:
- HOST_W, default 4: host address field width in the command byte; legal range 1..5.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- empty_i  in  1  FIFO empty
- data_i  in  8  FIFO read data; valid the cycle after readreq_o
- readreq_o  out  1  FIFO pop request
- connect_valid_o  out  1  one-cycle connect strobe
- disconnect_valid_o  out  1  one-cycle disconnect strobe
- host_addr_o  out  HOST_W  address of the last decoded command; held until the next command
- msg_start_o  out  1  one-cycle strobe when a send_data length byte is accepted
- msg_length_o  out  8  length byte of the current message; held
- payload_valid_o  out  1  payload byte available
- payload_data_o  out  8  payload byte
- payload_last_o  out  1  qualifies the final payload byte
- payload_ready_i  in  1  consumer accepts the payload byte
- error_o  out  1  one-cycle strobe on an illegal command byte
- msg_count_o  out  16  completed-message count (see Optional Feature)

Behaviour:
- Reset: clk and rst as above; reset is synchronous, active-high.
  - All outputs go to 0, the FSM goes to IDLE, and the outstanding-read flag is cleared.
  - Reset mid-frame abandons the frame. data_i returned for a read issued before reset is ignored.
- Read rule:
  - readreq_o=1 only when empty_i=0, no read is outstanding, and the FSM is in a *_REQ state.
  - At most one read is in flight, so the FIFO can never underflow.
- Command byte layout:
  - [2:0] = opcode: 000 connect, 001 disconnect, 010 send_data.
  - [2+HOST_W:3] = host address.
  - All bits above 2+HOST_W must be 0.
- FSM states: IDLE/CMD_REQ, CMD_WAIT, LEN_REQ, LEN_WAIT, PAY_REQ, PAY_WAIT, PAY_HOLD.
  - CMD_REQ: pop when the read rule allows, then go to CMD_WAIT.
  - CMD_WAIT, connect or disconnect:
    - Register host_addr_o.
    - Pulse the matching strobe on the next cycle (1-cycle latency from data_i).
    - Return to CMD_REQ.
  - CMD_WAIT, send_data: register host_addr_o, go to LEN_REQ.
  - CMD_WAIT, any other opcode or nonzero upper bits: pulse error_o, drop the byte, return to CMD_REQ.
  - LEN_REQ: pop, go to LEN_WAIT.
  - LEN_WAIT:
    - Register msg_length_o, pulse msg_start_o, load the remaining-byte counter with the length.
    - Length 0: the message is complete; return to CMD_REQ. No payload_valid_o is asserted.
    - Otherwise go to PAY_REQ.
  - PAY_REQ: pop, go to PAY_WAIT.
  - PAY_WAIT:
    - Capture data_i into the output register and set payload_valid_o.
    - payload_last_o = (remaining == 1).
    - Go to PAY_HOLD.
  - PAY_HOLD: hold payload_valid_o, payload_data_o and payload_last_o stable until payload_ready_i=1. On the accepting cycle:
    - Clear valid and decrement remaining.
    - If the accepted byte was last, go to CMD_REQ; otherwise go to PAY_REQ.
- Throughput: one payload byte per 3 cycles when the FIFO is non-empty and the consumer is always ready.
- Stalls:
  - empty_i=1 holds any *_REQ state indefinitely with no pop.
  - Low payload_ready_i holds PAY_HOLD indefinitely with no pop.
- Only one strobe output fires per cycle; the strobes are mutually exclusive by construction.
- The counter is 8 bit. Length 255 yields 255 payload bytes; there is no wrap.

Optional Feature:
- Macro: INTERFACE_OUT_MSG_COUNT_EN.
- Defined:
  - msg_count_o increments by 1 on the cycle the last payload byte is accepted, or on a length-0 message's msg_start_o.
  - It wraps 16'hFFFF -> 0 and resets to 0.
- Undefined: msg_count_o is tied to 16'h0 and no counter logic is built.

Test Plan:
- FIFO holds 8'h28 -> one read; host_addr_o=5; connect_valid_o high for exactly 1 cycle; no other strobe.
- FIFO holds 8'h19 -> disconnect_valid_o pulses once; host_addr_o=3.
- FIFO holds 12,03,AA,BB,CC with payload_ready_i=1:
  - msg_start_o pulses with msg_length_o=3 and host_addr_o=2.
  - Payload AA, BB, CC is delivered, with payload_last_o set only on CC.
  - msg_count_o=1 with the macro defined, 0 without.
- Same frame with payload_ready_i held low for 10 cycles at BB -> BB stays on payload_data_o; readreq_o stays 0 during the stall; CC follows after ready rises.
- FIFO holds 8'h03 then 8'h28 -> error_o pulses once, then a normal connect to host 5. FIFO holds 12,00 -> msg_start_o pulses, no payload_valid_o.
- Assert rst for 1 cycle while in PAY_HOLD of a length-3 frame -> all outputs 0. The next FIFO byte is decoded as a command byte.
